// File: rtl/scoreboard.sv
// Register scoreboard: tracks in-flight long-latency destinations and
// stalls ID until their writebacks land.
module scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       ra_addr_id,
  input  logic                ra_used_id,
  input  logic [AW-1:0]       rb_addr_id,
  input  logic                rb_used_id,
  input  logic [AW-1:0]       rd_addr_id,
  input  logic                rd_long_id,
  input  logic                hold,
  input  logic                flush_id,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd_addr,
  output logic                stall_id,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [31:0]         stall_cycles,
  output logic                underflow_err
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];

  logic ra_ok, rb_ok, rd_ok;
  logic raw_a, raw_b, waw;
  logic issue;
  logic wb_zero;

  assign ra_ok = !(ZERO_REG && ra_addr_id == '0);
  assign rb_ok = !(ZERO_REG && rb_addr_id == '0);
  assign rd_ok = !(ZERO_REG && rd_addr_id == '0);

  assign raw_a = id_valid && ra_used_id && ra_ok &&
                 (cnt_q[ra_addr_id] != '0);
  assign raw_b = id_valid && rb_used_id && rb_ok &&
                 (cnt_q[rb_addr_id] != '0);
  assign waw   = id_valid && rd_long_id && rd_ok &&
                 (cnt_q[rd_addr_id] == '1);

  // Purely from registered counts: a same-cycle WB does not release ID.
  assign stall_id = raw_a || raw_b || waw;

  assign issue = id_valid && rd_long_id && rd_ok &&
                 !stall_id && !hold && !flush_id;

  // Completion with nothing outstanding, unless an issue to the same
  // register cancels it out this cycle.
  assign wb_zero = wb_valid && (cnt_q[wb_rd_addr] == '0) &&
                   !(issue && rd_addr_id == wb_rd_addr);

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_mask[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        logic inc, dec;
        inc = issue && (rd_addr_id == AW'(r));
        dec = wb_valid && (wb_rd_addr == AW'(r));
        if (inc && !dec)
          cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        else if (dec && !inc && cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (stall_id && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (wb_zero)
        underflow_err <= 1'b1;
    end
  end

endmodule
